// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against a held
// long-latency result, and keeps a busy scoreboard for decode hazard detection.
module regfile_wb_sched #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_addr,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    output logic        hazard_stall,
    output logic        RegWEn,
    output logic [4:0]  AddrD,
    output logic [31:0] DataD
);

    localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

    logic        hold_valid_q, hold_valid_d;
    logic [4:0]  hold_addr_q, hold_addr_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        prio;
    logic        hold_drain;

    always_comb begin
        prio       = hold_valid_q && (starve_cnt_q >= StarveLim);
        hold_drain = hold_valid_q && (prio || !wb_en);
        AddrD      = hold_drain ? hold_addr_q : wb_addr;
        DataD      = hold_drain ? hold_data_q : wb_data;
        wb_stall   = !rst && wb_en && hold_drain;
        lu_ready   = !rst && (!hold_valid_q || hold_drain);
        // x0 writes are dropped at the port but the source still counts as served
        RegWEn     = !rst && (hold_drain || wb_en) && (AddrD != 5'd0);
        hazard_stall = !rst && (busy_q[id_rs1] || busy_q[id_rs2] || busy_q[id_rd]);
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        if (hold_drain) begin
            hold_valid_d = 1'b0;
        end
        if (lu_valid && lu_ready) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = lu_addr;
            hold_data_d  = lu_data;
        end

        starve_cnt_d = starve_cnt_q;
        if (!hold_valid_q || hold_drain) begin
            starve_cnt_d = 4'd0;
        end else if (wb_en && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // Set after clear so a same-edge re-issue keeps the register busy
        busy_d = busy_q;
        if (hold_drain) begin
            busy_d[hold_addr_q] = 1'b0;
        end
        if (lu_issue && (lu_issue_addr != 5'd0)) begin
            busy_d[lu_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= 5'd0;
            hold_data_q  <= 32'd0;
            busy_q       <= 32'd0;
            starve_cnt_q <= 4'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the write-port scheduler.
module tb_regfile_wb_sched;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        lu_issue;
    logic [4:0]  lu_issue_addr;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        hazard_stall;
    logic        RegWEn;
    logic [4:0]  AddrD;
    logic [31:0] DataD;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    bit          m_busy[32];
    bit          m_hv;
    logic [4:0]  m_ha;
    logic [31:0] m_hd;
    int          m_loss;
    bit          e_drain, e_ready, e_stall, e_we, e_haz;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    always #5 clk = ~clk;

    regfile_wb_sched #(.STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
        .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .hazard_stall(hazard_stall),
        .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD)
    );

    task automatic idle_inputs();
        wb_en = 0; wb_addr = 0; wb_data = 0;
        lu_issue = 0; lu_issue_addr = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 32; a++) m_busy[a] = 0;
        m_hv = 0; m_ha = 0; m_hd = 0; m_loss = 0;
    endtask

    // Expected outputs for the current cycle from the scheduling rules
    task automatic model_predict();
        e_drain = m_hv && (m_loss >= STARVE || !wb_en);
        e_ready = !rst && (!m_hv || e_drain);
        e_stall = !rst && wb_en && e_drain;
        e_addr  = e_drain ? m_ha : wb_addr;
        e_data  = e_drain ? m_hd : wb_data;
        e_we    = !rst && (e_drain || wb_en) && (e_addr != 0);
        e_haz   = !rst && (m_busy[id_rs1] || m_busy[id_rs2] || m_busy[id_rd]);
    endtask

    task automatic model_update();
        if (rst) begin
            model_clear();
        end else begin
            if (e_drain) begin
                m_busy[m_ha] = 0;
                m_hv = 0;
                m_loss = 0;
            end else if (m_hv && wb_en) begin
                m_loss++;
            end
            if (lu_issue && lu_issue_addr != 0) m_busy[lu_issue_addr] = 1;
            if (lu_valid && e_ready) begin
                m_hv = 1; m_ha = lu_addr; m_hd = lu_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        wb_en = 1; wb_addr = 5; lu_valid = 1; lu_issue = 1; lu_issue_addr = 6; id_rs1 = 6;
        #1;
        n_checks++;
        if ({RegWEn, lu_ready, wb_stall, hazard_stall} !== 4'b0000)
            $display("FAIL reset_outputs: got %b, want 0000",
                     {RegWEn, lu_ready, wb_stall, hazard_stall});
        else n_pass++;
        tick();
        tick();
        idle_inputs();
        rst = 0;
        tick();
        id_rs1 = 6;
        #1;
        n_checks++;
        if ({RegWEn, lu_ready, hazard_stall} !== 3'b010)
            $display("FAIL reset_release: got %b, want 010", {RegWEn, lu_ready, hazard_stall});
        else n_pass++;
        tick();
    endtask

    task automatic test_wb_basic();
        do_reset();
        wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if ({RegWEn, AddrD, DataD, wb_stall} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0})
            $display("FAIL wb_write: got we=%b a=%0d d=%h st=%b, want we=1 a=5 d=deadbeef st=0",
                     RegWEn, AddrD, DataD, wb_stall);
        else n_pass++;
        tick();
        wb_addr = 0; wb_data = 32'h11111111;
        #1;
        n_checks++;
        if (RegWEn !== 1'b0) $display("FAIL wb_x0: got we=%b, want 0", RegWEn);
        else n_pass++;
        tick();
        wb_addr = 31; wb_data = $urandom;
        #1;
        n_checks++;
        if ({RegWEn, AddrD, DataD} !== {1'b1, 5'd31, wb_data})
            $display("FAIL wb_x31: got we=%b a=%0d d=%h, want we=1 a=31 d=%h",
                     RegWEn, AddrD, DataD, wb_data);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_lu_hazard();
        do_reset();
        lu_issue = 1; lu_issue_addr = 7;
        tick();
        lu_issue = 0;
        id_rs1 = 7;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) $display("FAIL haz_rs1: got %b, want 1", hazard_stall);
        else n_pass++;
        id_rs1 = 0; id_rd = 7;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) $display("FAIL haz_waw: got %b, want 1", hazard_stall);
        else n_pass++;
        id_rd = 0; id_rs1 = 7;
        lu_valid = 1; lu_addr = 7; lu_data = 32'h1234;
        #1;
        n_checks++;
        if (lu_ready !== 1'b1) $display("FAIL lu_accept: got ready=%b, want 1", lu_ready);
        else n_pass++;
        tick();
        lu_valid = 0;
        #1;
        n_checks++;
        if ({RegWEn, AddrD, DataD, hazard_stall} !== {1'b1, 5'd7, 32'h1234, 1'b1})
            $display("FAIL lu_write: got we=%b a=%0d d=%h hz=%b, want we=1 a=7 d=1234 hz=1",
                     RegWEn, AddrD, DataD, hazard_stall);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if ({RegWEn, hazard_stall} !== 2'b00)
            $display("FAIL lu_after: got we=%b hz=%b, want 0 0", RegWEn, hazard_stall);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_starve();
        int stalls = 0;
        int since = 0;
        int wr = 0;
        int gap[2];
        logic [4:0] exp_a;
        logic [31:0] exp_d;
        gap[0] = -1; gap[1] = -1;
        do_reset();
        lu_valid = 1; lu_addr = 3; lu_data = 32'hA5A50003;
        tick();
        lu_valid = 0;
        for (int cyc = 0; cyc < 16 && stalls < 2; cyc++) begin
            wb_en = 1; wb_addr = 5'(10 + wr); wb_data = 32'hB0000000 + 32'(wr);
            #1;
            if (wb_stall) begin
                exp_a = (stalls == 0) ? 5'd3 : 5'd4;
                exp_d = (stalls == 0) ? 32'hA5A50003 : 32'hA5A50004;
                n_checks++;
                if ({RegWEn, AddrD, DataD} !== {1'b1, exp_a, exp_d})
                    $display("FAIL starve_drain: got we=%b a=%0d d=%h, want we=1 a=%0d d=%h",
                             RegWEn, AddrD, DataD, exp_a, exp_d);
                else n_pass++;
                gap[stalls] = since;
                since = 0;
                stalls++;
                if (stalls == 1) begin
                    lu_valid = 1; lu_addr = 4; lu_data = 32'hA5A50004;
                    n_checks++;
                    if (lu_ready !== 1'b1)
                        $display("FAIL starve_reaccept: got ready=%b, want 1", lu_ready);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if ({RegWEn, AddrD, DataD} !== {1'b1, wb_addr, wb_data})
                    $display("FAIL starve_pipe: got we=%b a=%0d d=%h, want we=1 a=%0d d=%h",
                             RegWEn, AddrD, DataD, wb_addr, wb_data);
                else n_pass++;
                since++;
                wr++;
            end
            tick();
            lu_valid = 0;
        end
        n_checks++;
        if (gap[0] != STARVE) $display("FAIL starve_gap0: got %0d, want %0d", gap[0], STARVE);
        else n_pass++;
        n_checks++;
        if (gap[1] != STARVE) $display("FAIL starve_gap1: got %0d, want %0d", gap[1], STARVE);
        else n_pass++;
        wb_addr = 5'd20; wb_data = 32'hC0DE0020;
        #1;
        n_checks++;
        if ({wb_stall, RegWEn, AddrD} !== {1'b0, 1'b1, 5'd20})
            $display("FAIL starve_resume: got st=%b we=%b a=%0d, want st=0 we=1 a=20",
                     wb_stall, RegWEn, AddrD);
        else n_pass++;
        tick();
        idle_inputs();
    endtask

    task automatic test_same_edge();
        do_reset();
        lu_issue = 1; lu_issue_addr = 9;
        tick();
        lu_issue = 0;
        lu_valid = 1; lu_addr = 9; lu_data = 32'h9999;
        tick();
        lu_valid = 0;
        lu_issue = 1; lu_issue_addr = 9;
        #1;
        n_checks++;
        if ({RegWEn, AddrD} !== {1'b1, 5'd9})
            $display("FAIL same_drain: got we=%b a=%0d, want we=1 a=9", RegWEn, AddrD);
        else n_pass++;
        tick();
        lu_issue = 0;
        id_rs2 = 9;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) $display("FAIL same_busy9: got %b, want 1", hazard_stall);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_stream();
        logic [31:0] dat[8];
        int writes = 0;
        do_reset();
        for (int i = 0; i < 8; i++) dat[i] = $urandom;
        for (int i = 0; i < 9; i++) begin
            lu_valid = (i < 8);
            lu_addr  = 5'(i + 1);
            lu_data  = (i < 8) ? dat[i] : 32'd0;
            #1;
            if (i < 8) begin
                n_checks++;
                if (lu_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b, want 1", i, lu_ready);
                else n_pass++;
            end
            if (i > 0) begin
                n_checks++;
                if ({RegWEn, AddrD, DataD} !== {1'b1, 5'(i), dat[i-1]})
                    $display("FAIL stream_write%0d: got we=%b a=%0d d=%h, want we=1 a=%0d d=%h",
                             i, RegWEn, AddrD, DataD, i, dat[i-1]);
                else n_pass++;
                if (RegWEn) writes++;
            end
            tick();
        end
        lu_valid = 0;
        n_checks++;
        if (writes != 8) $display("FAIL stream_count: got %0d, want 8", writes);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lu_issue = 1; lu_issue_addr = 12;
        tick();
        lu_issue_addr = 13;
        lu_valid = 1; lu_addr = 12; lu_data = 32'h12121212;
        tick();
        idle_inputs();
        rst = 1;
        #1;
        n_checks++;
        if (RegWEn !== 1'b0) $display("FAIL rstmid_nowrite: got we=%b, want 0", RegWEn);
        else n_pass++;
        tick();
        tick();
        rst = 0;
        #1;
        n_checks++;
        if ({RegWEn, lu_ready} !== 2'b01)
            $display("FAIL rstmid_release: got we=%b rdy=%b, want 0 1", RegWEn, lu_ready);
        else n_pass++;
        for (int a = 0; a < 32; a++) begin
            id_rs1 = 5'(a); id_rs2 = 5'(a); id_rd = 5'(a);
            #1;
            n_checks++;
            if (hazard_stall !== 1'b0) $display("FAIL rstmid_busy%0d: got 1, want 0", a);
            else n_pass++;
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [40:0] got, want;
        do_reset();
        model_clear();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            wb_en         = ($urandom_range(0, 9) < 7);
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            lu_issue      = ($urandom_range(0, 3) == 0);
            lu_issue_addr = 5'($urandom_range(0, 7));
            lu_valid      = ($urandom_range(0, 2) == 0);
            lu_addr       = 5'($urandom_range(0, 7));
            lu_data       = $urandom;
            id_rs1        = 5'($urandom_range(0, 7));
            id_rs2        = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 7));
            #1;
            model_predict();
            got  = {RegWEn, e_we ? AddrD : 5'd0, e_we ? DataD : 32'd0,
                    wb_stall, lu_ready, hazard_stall};
            want = {e_we, e_we ? e_addr : 5'd0, e_we ? e_data : 32'd0,
                    e_stall, e_ready, e_haz};
            n_checks++;
            if (got !== want)
                $display("FAIL random_cyc%0d: got {we,a,d,st,rdy,hz}=%h, want %h", i, got, want);
            else n_pass++;
            model_update();
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_wb_basic();
        test_lu_hazard();
        test_starve();
        test_same_edge();
        test_stream();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and scoreboard for the 32x32 register file. It shares the single write port (RegWEn/AddrD/DataD) between the in-order pipeline writeback and one long-latency unit (load/divide) that returns results out of order. It tracks destination registers with outstanding long-latency results and flags decode hazards. It sits between the writeback stage, the long-latency unit, decode, and the register file write port.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a held long-latency result may lose to pipeline writeback before it takes priority (1..15).

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_en  in  1  pipeline writeback request
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline writeback data
- wb_stall  out  1  pipeline write not performed this cycle; writeback stage holds wb_en/wb_addr/wb_data
- lu_issue  in  1  long-latency op issued this cycle
- lu_issue_addr  in  5  its destination register
- lu_valid  in  1  long-latency result offered
- lu_addr  in  5  result destination
- lu_data  in  32  result data
- lu_ready  out  1  result accepted on this edge when lu_valid=1
- id_rs1, id_rs2, id_rd  in  5 each  decode-stage source and destination registers
- hazard_stall  out  1  decode must stall
- RegWEn  out  1  register file write enable
- AddrD  out  5  register file write address
- DataD  out  32  register file write data

## Operation
- State:
  - hold_valid, hold_addr[4:0], hold_data[31:0]: 1-entry holding register for a long-latency result.
  - busy[31:0]: scoreboard.
  - starve_cnt: 4-bit counter.
- Acceptance:
  - lu_ready = !rst && (!hold_valid || hold_drain), where hold_drain means the held entry is written this cycle.
  - On lu_valid && lu_ready: capture lu_addr and lu_data; hold_valid=1.
- Write-port arbitration, combinational, each cycle:
  - prio = hold_valid && starve_cnt >= STARVE_LIMIT.
  - If prio, or (hold_valid && !wb_en): hold drains; AddrD=hold_addr, DataD=hold_data.
  - Else if wb_en: pipeline writes; AddrD=wb_addr, DataD=wb_data.
  - wb_stall = wb_en && hold_drain.
  - RegWEn = !rst && (hold_drain || (wb_en && !wb_stall)) && AddrD != 0. Writes to x0 are suppressed, but the source is still considered served.
- starve_cnt:
  - Cleared on reset, on hold_drain, or when !hold_valid.
  - Otherwise increments when hold_valid && wb_en && !hold_drain.
  - Saturates at 15.
- Scoreboard:
  - lu_issue with lu_issue_addr != 0 sets busy[lu_issue_addr].
  - hold_drain clears busy[hold_addr].
  - If set and clear hit the same address on the same edge, set wins.
  - busy[0] is always 0.
- hazard_stall = !rst && (busy[id_rs1] || busy[id_rs2] || busy[id_rd]). The id_rd term is the WAW guard. This is purely combinational from current busy.

## Timing
- Reset values: hold_valid=0, busy=0, starve_cnt=0.
- Outputs while rst=1: RegWEn=0, lu_ready=0, wb_stall=0, hazard_stall=0.
- Reset mid-operation discards any held result and all busy bits.
- Pipeline writeback latency:
  - 0 cycles: RegWEn is combinational from wb_en when not stalled.
  - Written on the same edge.
- Long-latency latency:
  - Accepted at edge N.
  - Earliest register file write at edge N+1.
  - busy clears at the same edge; hazard_stall drops in cycle N+1 after that edge. The register file reads asynchronously, so decode sees the new value.
- Back-to-back: a result may be accepted on the same edge the held entry drains, for 1 result/cycle throughput when wb_en=0.
- Worst case, a held result waits STARVE_LIMIT cycles under continuous wb_en, then drains in the next cycle with wb_stall=1 for that one cycle.

## Test plan
- Reset, then wb_en=1, wb_addr=5, wb_data=0xDEADBEEF:
  - Required: RegWEn=1, AddrD=5, DataD=0xDEADBEEF in the same cycle.
  - wb_addr=0: RegWEn=0.
- lu_issue with addr 7, then id_rs1=7:
  - Required: hazard_stall=1.
  - Then lu_valid with addr 7, data 0x1234 accepted at edge N, wb_en=0: write at edge N+1 and hazard_stall=0 after it.
- Collision: hold_valid with addr 3; wb_en=1 continuously, STARVE_LIMIT=4:
  - Required: 4 pipeline writes, then 1 cycle with wb_stall=1 and AddrD=3, then pipeline resumes.
  - starve_cnt returns to 0.
- Same-edge lu_issue addr 9 and drain of held addr 9:
  - Required: busy[9] remains 1.
- Streaming lu_valid for 8 consecutive cycles with wb_en=0:
  - Required: lu_ready=1 every cycle and 8 writes on consecutive edges.
- Assert rst with hold_valid=1 and busy bits set:
  - Required: no write occurs; after deassertion, hazard_stall=0 for all addresses and lu_ready=1.
